// File: rtl/key_conditioner.sv
// Synchronises, debounces and chord-filters four active-low push buttons
// into a clean one-hot key code with a single press pulse per physical press.
module key_conditioner #(
    parameter int CLOCK_FREQ      = 50000000,
    parameter int DEBOUNCE_CYCLES = CLOCK_FREQ / 50,
    parameter int COUNTER_WIDTH   = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_n_raw,
    output logic [3:0] key,
    output logic       key_pressed,
    output logic       chord_error
);

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        PRESSED,
        DB_RELEASE,
        LOCKOUT
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;

    state_t                   state, state_nxt;
    logic [3:0]               sync1, s, s_q;
    logic [3:0]               cand, cand_d;
    logic [3:0]               key_d;
    logic                     pressed_d;
    logic                     cnt_clr;
    logic [COUNTER_WIDTH-1:0] counter, counter_d;
    logic                     s_zero, s_one_hot, s_multi, cnt_done;

    assign s_zero    = (s == 4'b0000);
    assign s_one_hot = !s_zero && ((s & (s - 4'd1)) == 4'b0000);
    assign s_multi   = !s_zero && !s_one_hot;
    assign cnt_done  = (counter == CNT_LAST);

    // Stability counter: restarts on any change of s, saturates instead of wrapping.
    always_comb begin
        if (cnt_clr || (s != s_q))
            counter_d = '0;
        else if (counter == CNT_MAX)
            counter_d = counter;
        else
            counter_d = counter + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1       <= '0;
            s           <= '0;
            s_q         <= '0;
            cand        <= '0;
            counter     <= '0;
            key         <= '0;
            key_pressed <= 1'b0;
            state       <= IDLE;
        end else begin
            sync1       <= ~key_n_raw;
            s           <= sync1;
            s_q         <= s;
            cand        <= cand_d;
            counter     <= counter_d;
            key         <= key_d;
            key_pressed <= pressed_d;
            state       <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (s_one_hot)
                    state_nxt = DB_PRESS;
                else if (s_multi)
                    state_nxt = LOCKOUT;
            end
            DB_PRESS: begin
                if (s != cand)
                    state_nxt = IDLE;
                else if (cnt_done)
                    state_nxt = PRESSED;
            end
            PRESSED: begin
                if (s_zero)
                    state_nxt = DB_RELEASE;
            end
            DB_RELEASE: begin
                if (!s_zero)
                    state_nxt = PRESSED;
                else if (cnt_done)
                    state_nxt = IDLE;
            end
            LOCKOUT: begin
                if (s_zero && cnt_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        key_d       = key;
        pressed_d   = 1'b0;
        cand_d      = cand;
        cnt_clr     = 1'b0;
        chord_error = (state == LOCKOUT);
        case (state)
            IDLE: begin
                key_d = '0;
                if (s_one_hot) begin
                    cand_d  = s;
                    cnt_clr = 1'b1;
                end
            end
            DB_PRESS: begin
                if ((s == cand) && cnt_done) begin
                    key_d     = cand;
                    pressed_d = 1'b1;
                end
            end
            PRESSED: begin
                key_d = cand;
                if (s_zero)
                    cnt_clr = 1'b1;
            end
            DB_RELEASE: begin
                key_d = cand;
                if (s_zero && cnt_done)
                    key_d = '0;
            end
            LOCKOUT: key_d = '0;
            default: key_d = '0;
        endcase
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed, table-driven bench for key_conditioner with an 8-cycle debounce.
module tb_key_conditioner;

    logic       clock;
    logic       reset;
    logic [3:0] key_n_raw;
    logic [3:0] key;
    logic       key_pressed;
    logic       chord_error;

    int unsigned tests    = 0;
    int unsigned failures = 0;
    int unsigned kp_count = 0;
    logic        multi_hot_seen = 1'b0;

    key_conditioner #(
        .CLOCK_FREQ     (50000000),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_n_raw  (key_n_raw),
        .key        (key),
        .key_pressed(key_pressed),
        .chord_error(chord_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (key_pressed) kp_count <= kp_count + 1;
        if ($countones(key) > 1) multi_hot_seen <= 1'b1;
    end

    typedef struct {
        logic [3:0]  raw;
        int unsigned cycles;
        logic [3:0]  exp_key;
        logic        exp_kp;
        logic        exp_ce;
    } vec_t;

    vec_t vecs[13];

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] ek, input logic ekp, input logic ece);
        tests++;
        if (key !== ek || key_pressed !== ekp || chord_error !== ece) begin
            failures++;
            $display("FAIL %s: key=%b kp=%b ce=%b, required key=%b kp=%b ce=%b",
                     name, key, key_pressed, chord_error, ek, ekp, ece);
        end
    endtask

    task automatic check_int(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    initial begin
        int unsigned c0;

        vecs[0]  = '{4'b1110, 10, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{4'b1110,  1, 4'b0001, 1'b1, 1'b0};
        vecs[2]  = '{4'b1110,  1, 4'b0001, 1'b0, 1'b0};
        vecs[3]  = '{4'b1110,  8, 4'b0001, 1'b0, 1'b0};
        vecs[4]  = '{4'b1111, 10, 4'b0001, 1'b0, 1'b0};
        vecs[5]  = '{4'b1111,  1, 4'b0000, 1'b0, 1'b0};
        vecs[6]  = '{4'b1111,  5, 4'b0000, 1'b0, 1'b0};
        vecs[7]  = '{4'b1100,  2, 4'b0000, 1'b0, 1'b0};
        vecs[8]  = '{4'b1100,  1, 4'b0000, 1'b0, 1'b1};
        vecs[9]  = '{4'b1100, 17, 4'b0000, 1'b0, 1'b1};
        vecs[10] = '{4'b1111, 10, 4'b0000, 1'b0, 1'b1};
        vecs[11] = '{4'b1111,  1, 4'b0000, 1'b0, 1'b0};
        vecs[12] = '{4'b1111,  5, 4'b0000, 1'b0, 1'b0};

        reset     = 1'b0;
        key_n_raw = 4'b1111;
        step(3);
        check("reset_state", 4'b0000, 1'b0, 1'b0);
        reset = 1'b1;
        step(3);
        check("idle_after_reset", 4'b0000, 1'b0, 1'b0);

        // Clean press/release and chord rejection
        c0 = kp_count;
        for (int i = 0; i < 13; i++) begin
            key_n_raw = vecs[i].raw;
            step(vecs[i].cycles);
            check($sformatf("vec%0d", i), vecs[i].exp_key, vecs[i].exp_kp, vecs[i].exp_ce);
        end
        check_int("clean_press_pulses", kp_count - c0, 1);

        // Bounce on KEY2: five toggles three cycles apart, last one leaves it low
        c0 = kp_count;
        for (int t = 0; t < 5; t++) begin
            key_n_raw = (t % 2 == 0) ? 4'b1011 : 4'b1111;
            if (t < 4) step(3);
        end
        step(10);
        check("bounce_before", 4'b0000, 1'b0, 1'b0);
        step(1);
        check("bounce_rise", 4'b0100, 1'b1, 1'b0);
        step(1);
        check_int("bounce_pulses", kp_count - c0, 1);
        key_n_raw = 4'b1111;
        step(12);
        check("bounce_released", 4'b0000, 1'b0, 1'b0);

        // Add KEY3 while KEY1 is held
        c0 = kp_count;
        key_n_raw = 4'b1101;
        step(11);
        check("add_first", 4'b0010, 1'b1, 1'b0);
        key_n_raw = 4'b0101;
        for (int i = 0; i < 15; i++) begin
            step(1);
            check($sformatf("add_hold%0d", i), 4'b0010, 1'b0, 1'b0);
        end
        key_n_raw = 4'b1111;
        step(10);
        check("add_release_late", 4'b0010, 1'b0, 1'b0);
        step(1);
        check("add_release", 4'b0000, 1'b0, 1'b0);
        check_int("add_pulses", kp_count - c0, 1);
        step(3);

        // Short release glitch while KEY3 held
        c0 = kp_count;
        key_n_raw = 4'b0111;
        step(12);
        check("glitch_held", 4'b1000, 1'b0, 1'b0);
        key_n_raw = 4'b1111;
        step(4);
        key_n_raw = 4'b0111;
        for (int i = 0; i < 14; i++) begin
            step(1);
            check($sformatf("glitch%0d", i), 4'b1000, 1'b0, 1'b0);
        end
        key_n_raw = 4'b1111;
        step(11);
        check("glitch_release", 4'b0000, 1'b0, 1'b0);
        check_int("glitch_pulses", kp_count - c0, 1);
        step(3);

        // Reset while KEY0 is held, then re-report after reset releases
        key_n_raw = 4'b1110;
        step(11);
        check("rst_pre", 4'b0001, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1 check("rst_async", 4'b0000, 1'b0, 1'b0);
        step(2);
        reset = 1'b1;
        c0 = kp_count;
        step(10);
        check("rst_before", 4'b0000, 1'b0, 1'b0);
        step(1);
        check("rst_rereport", 4'b0001, 1'b1, 1'b0);
        step(1);
        check_int("rst_pulses", kp_count - c0, 1);
        key_n_raw = 4'b1111;
        step(12);
        check("rst_released", 4'b0000, 1'b0, 1'b0);

        check_int("multi_hot_seen", int'(multi_hot_seen), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
